pe_data_xbar: RTL and testbench
===============================

// Module: pe_data_xbar
// PURPOSE
//  Parametrised PE data-side interconnect: one CPU data port, N_DMA DMA masters, one shared
//  single-port data memory, N_PERIPH MMIO slaves (PLIC, RTC, DMNI cfg, ...).
//  Decodes CPU addresses to memory or MMIO, arbitrates memory between CPU and DMAs with
//  bounded DMA starvation, and routes read data back with fixed 1-cycle latency.
// PARAMETERS
//  N_DMA        1     number of DMA masters (1..4)
//  N_PERIPH     3     number of MMIO slaves (1..16)
//  MMIO_NIBBLE  4'h2  addr[31:28] value that selects MMIO space
//  MAX_WAIT     4     max consecutive cycles a requesting DMA may lose to the CPU (1..15)
// PORTS
//  clk_i        in   1           clock
//  rst_ni       in   1           async active-low reset
//  cpu_en_i     in   1           CPU access request
//  cpu_we_i     in   4           CPU byte write enables (0 = read)
//  cpu_addr_i   in   32          CPU address
//  cpu_data_i   in   32          CPU write data
//  cpu_data_o   out  32          CPU read data, valid cycle after accepted read
//  cpu_stall_o  out  1           CPU request not accepted this cycle; hold request
//  per_en_o     out  N_PERIPH    one-hot MMIO select
//  per_we_o     out  4           MMIO byte write enables (copy of cpu_we_i)
//  per_addr_o   out  32          MMIO address (copy of cpu_addr_i)
//  per_data_o   out  32          MMIO write data
//  per_data_i   in   32*N_PERIPH MMIO read data, slave k at [32k+:32], valid in access cycle
//  dma_req_i    in   N_DMA       DMA access request
//  dma_we_i     in   4*N_DMA     DMA byte write enables
//  dma_addr_i   in   32*N_DMA    DMA address (always memory space)
//  dma_data_i   in   32*N_DMA    DMA write data
//  dma_gnt_o    out  N_DMA       DMA access accepted this cycle
//  dma_rvalid_o out  N_DMA       DMA read data valid (1 cycle after granted read)
//  dma_data_o   out  32          DMA read data (broadcast)
//  dec_err_o    out  1           1-cycle pulse: CPU MMIO access to index >= N_PERIPH
//  mem_en_o     out  1           memory enable
//  mem_we_o     out  4           memory byte write enables
//  mem_addr_o   out  32          memory address
//  mem_data_o   out  32          memory write data
//  mem_data_i   in   32          memory read data, 1-cycle latency
// BEHAVIOUR
//  Decode (comb): mmio = cpu_en_i & addr[31:28]==MMIO_NIBBLE; idx = addr[27:24].
//   mmio & idx<N_PERIPH -> per_en_o[idx]=1, never stalls; idx>=N_PERIPH -> no slave enabled,
//   writes dropped, dec_err_o pulses next cycle, read returns 32'h0.
//  Memory arbitration (comb grant, registered state):
//   cpu_mem = cpu_en_i & !mmio. Default CPU wins; all DMAs lose.
//   starve_cnt (4b) +1 each cycle any DMA requests and none granted; 0 on any DMA grant or no DMA req.
//   starve_cnt==MAX_WAIT or !cpu_mem -> DMA wins; cpu_stall_o = cpu_mem.
//   DMA winner: round-robin from rr_ptr; after grant rr_ptr = winner+1 mod N_DMA.
//   Exactly one mem master per cycle; mem_en_o=0 and mem_we_o=0 when no master.
//   A CPU MMIO access and a DMA memory access proceed in the same cycle.
//  Read return: registered tag {valid, src(CPU_MEM|CPU_PER|CPU_ERR|DMA), idx} per accepted read
//   (we==0). Writes produce no tag.
//   CPU_MEM -> cpu_data_o=mem_data_i; CPU_PER -> cpu_data_o=registered per_data_i[idx];
//   CPU_ERR -> 0; no valid CPU tag -> cpu_data_o holds last value.
//   DMA -> dma_rvalid_o[idx]=1; dma_data_o=mem_data_i always.
//  Back-to-back accesses every cycle supported; no bubble between accepted requests.
//  Reset: all outputs 0, cpu_data_o=0, starve_cnt=0, rr_ptr=0, tags invalid; reset mid-read
//   drops the pending return (no rvalid after release).
// TESTING
//  CPU read 0x0000_0100 alone, mem returns 0xCAFE0001 -> mem_en cycle0, cpu_data_o=0xCAFE0001 cycle1, stall=0.
//  CPU streams memory reads, DMA0 requests continuously, MAX_WAIT=4 -> DMA0 granted every 5th cycle, stall=1 that cycle only.
//  N_DMA=3 all requesting, CPU idle -> grants 0,1,2,0,... ; rvalid matches grantee one cycle later.
//  CPU write 0x2100_0000 with DMA1 read same cycle -> per_en_o=3'b010 and dma_gnt_o[1]=1 both, no stall.
//  CPU read 0x2F00_0004 (N_PERIPH=3) -> no per_en, dec_err_o pulse, cpu_data_o=0 next cycle.
//  rst_ni low in cycle after granted DMA read -> dma_rvalid_o stays 0, counters 0 after release.

Source files
------------

// File: rtl/pe_data_xbar_if.sv
// Bus bundle for the PE data-side crossbar: CPU port, DMA masters, memory and MMIO slaves.
// The slave modport is the crossbar's view; the master modport is the surrounding system's.
interface pe_data_xbar_if #(
  parameter int unsigned N_DMA    = 1,
  parameter int unsigned N_PERIPH = 3
);
  logic                    cpu_en_i;
  logic [3:0]              cpu_we_i;
  logic [31:0]             cpu_addr_i;
  logic [31:0]             cpu_data_i;
  logic [31:0]             cpu_data_o;
  logic                    cpu_stall_o;
  logic [N_PERIPH-1:0]     per_en_o;
  logic [3:0]              per_we_o;
  logic [31:0]             per_addr_o;
  logic [31:0]             per_data_o;
  logic [32*N_PERIPH-1:0]  per_data_i;
  logic [N_DMA-1:0]        dma_req_i;
  logic [4*N_DMA-1:0]      dma_we_i;
  logic [32*N_DMA-1:0]     dma_addr_i;
  logic [32*N_DMA-1:0]     dma_data_i;
  logic [N_DMA-1:0]        dma_gnt_o;
  logic [N_DMA-1:0]        dma_rvalid_o;
  logic [31:0]             dma_data_o;
  logic                    dec_err_o;
  logic                    mem_en_o;
  logic [3:0]              mem_we_o;
  logic [31:0]             mem_addr_o;
  logic [31:0]             mem_data_o;
  logic [31:0]             mem_data_i;

  modport slave (
    input  cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i, per_data_i,
           dma_req_i, dma_we_i, dma_addr_i, dma_data_i, mem_data_i,
    output cpu_data_o, cpu_stall_o, per_en_o, per_we_o, per_addr_o, per_data_o,
           dma_gnt_o, dma_rvalid_o, dma_data_o, dec_err_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i, per_data_i,
           dma_req_i, dma_we_i, dma_addr_i, dma_data_i, mem_data_i,
    input  cpu_data_o, cpu_stall_o, per_en_o, per_we_o, per_addr_o, per_data_o,
           dma_gnt_o, dma_rvalid_o, dma_data_o, dec_err_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/pe_data_xbar.sv
// PE data-side interconnect: CPU address decode to memory/MMIO, memory arbitration between
// the CPU and N_DMA DMA masters with bounded DMA starvation, and 1-cycle read data return.
module pe_data_xbar #(
  parameter int unsigned N_DMA       = 1,
  parameter int unsigned N_PERIPH    = 3,
  parameter logic [3:0]  MMIO_NIBBLE = 4'h2,
  parameter int unsigned MAX_WAIT    = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  pe_data_xbar_if.slave    bus
);

  localparam int unsigned PW = (N_DMA > 1) ? $clog2(N_DMA) : 1;

  typedef enum logic [1:0] {SRC_MEM, SRC_PER, SRC_ERR} cpu_src_e;

  logic                mmio, per_hit, per_miss, cpu_mem, cpu_gnt;
  logic [3:0]          idx;
  logic [31:0]         per_sel;
  logic [N_PERIPH-1:0] per_en;
  logic                any_req, dma_win, found;
  logic [PW-1:0]       win;
  logic [31:0]         cpu_data;

  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          cpu_rd_vld_q, cpu_rd_vld_d;
  cpu_src_e      cpu_src_q, cpu_src_d;
  logic [31:0]   per_rdata_q, per_rdata_d;
  logic [31:0]   cpu_data_q, cpu_data_d;
  logic          dma_rd_vld_q, dma_rd_vld_d;
  logic [PW-1:0] dma_rd_idx_q, dma_rd_idx_d;
  logic          dec_err_q, dec_err_d;

  // CPU address decode and MMIO slave select / read-data mux
  always_comb begin
    mmio     = bus.cpu_en_i & (bus.cpu_addr_i[31:28] == MMIO_NIBBLE);
    idx      = bus.cpu_addr_i[27:24];
    per_hit  = mmio & (32'(idx) < N_PERIPH);
    per_miss = mmio & ~per_hit;
    cpu_mem  = bus.cpu_en_i & ~mmio;
    per_sel  = '0;
    per_en   = '0;
    for (int unsigned k = 0; k < N_PERIPH; k++) begin
      if (idx == 4'(k)) begin
        per_sel   = bus.per_data_i[32*k +: 32];
        per_en[k] = per_hit;
      end
    end
  end

  // Memory arbitration: CPU by default, DMA when CPU is off memory or a DMA has waited MAX_WAIT
  always_comb begin
    any_req = |bus.dma_req_i;
    win     = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < N_DMA; off++) begin
      if (!found && bus.dma_req_i[PW'((32'(rr_ptr_q) + off) % N_DMA)]) begin
        found = 1'b1;
        win   = PW'((32'(rr_ptr_q) + off) % N_DMA);
      end
    end
    dma_win      = any_req & (~cpu_mem | (starve_cnt_q == 4'(MAX_WAIT)));
    cpu_gnt      = cpu_mem & ~dma_win;
    starve_cnt_d = (any_req & ~dma_win) ? starve_cnt_q + 4'd1 : '0;
    rr_ptr_d     = dma_win ? PW'((32'(win) + 1) % N_DMA) : rr_ptr_q;

    bus.dma_gnt_o  = '0;
    bus.mem_en_o   = 1'b0;
    bus.mem_we_o   = '0;
    bus.mem_addr_o = '0;
    bus.mem_data_o = '0;
    if (dma_win) begin
      bus.dma_gnt_o[win] = 1'b1;
      bus.mem_en_o       = 1'b1;
      bus.mem_we_o       = bus.dma_we_i[4*win +: 4];
      bus.mem_addr_o     = bus.dma_addr_i[32*win +: 32];
      bus.mem_data_o     = bus.dma_data_i[32*win +: 32];
    end else if (cpu_gnt) begin
      bus.mem_en_o   = 1'b1;
      bus.mem_we_o   = bus.cpu_we_i;
      bus.mem_addr_o = bus.cpu_addr_i;
      bus.mem_data_o = bus.cpu_data_i;
    end
  end

  // Read-return tags and CPU read data; cpu_data_q keeps the last returned word
  always_comb begin
    cpu_rd_vld_d = bus.cpu_en_i & (bus.cpu_we_i == '0) & (mmio | cpu_gnt);
    cpu_src_d    = per_hit ? SRC_PER : (per_miss ? SRC_ERR : SRC_MEM);
    per_rdata_d  = per_sel;
    dma_rd_vld_d = dma_win & (bus.dma_we_i[4*win +: 4] == '0);
    dma_rd_idx_d = win;
    dec_err_d    = per_miss;

    cpu_data = cpu_data_q;
    if (cpu_rd_vld_q) begin
      case (cpu_src_q)
        SRC_MEM: cpu_data = bus.mem_data_i;
        SRC_PER: cpu_data = per_rdata_q;
        default: cpu_data = '0;
      endcase
    end
    cpu_data_d = cpu_data;

    bus.dma_rvalid_o = '0;
    if (dma_rd_vld_q) bus.dma_rvalid_o[dma_rd_idx_q] = 1'b1;
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
      rr_ptr_q     <= '0;
      cpu_rd_vld_q <= 1'b0;
      cpu_src_q    <= SRC_MEM;
      per_rdata_q  <= '0;
      cpu_data_q   <= '0;
      dma_rd_vld_q <= 1'b0;
      dma_rd_idx_q <= '0;
      dec_err_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      cpu_rd_vld_q <= cpu_rd_vld_d;
      cpu_src_q    <= cpu_src_d;
      per_rdata_q  <= per_rdata_d;
      cpu_data_q   <= cpu_data_d;
      dma_rd_vld_q <= dma_rd_vld_d;
      dma_rd_idx_q <= dma_rd_idx_d;
      dec_err_q    <= dec_err_d;
    end
  end

  assign bus.cpu_data_o  = cpu_data;
  assign bus.cpu_stall_o = cpu_mem & dma_win;
  assign bus.per_en_o    = per_en;
  assign bus.per_we_o    = bus.cpu_we_i;
  assign bus.per_addr_o  = bus.cpu_addr_i;
  assign bus.per_data_o  = bus.cpu_data_i;
  assign bus.dma_data_o  = bus.mem_data_i;
  assign bus.dec_err_o   = dec_err_q;

endmodule

// File: tb/tb_pe_data_xbar.sv
// Randomised scoreboard bench for pe_data_xbar (N_DMA=3, N_PERIPH=3, MAX_WAIT=4).
module tb_pe_data_xbar;
  localparam int unsigned ND = 3;
  localparam int unsigned NP = 3;
  localparam int unsigned MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_data_xbar_if #(.N_DMA(ND), .N_PERIPH(NP)) bus ();

  pe_data_xbar #(.N_DMA(ND), .N_PERIPH(NP), .MMIO_NIBBLE(4'h2), .MAX_WAIT(MW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct { int unsigned due; logic [31:0] data; } cexp_t;
  typedef struct { int unsigned due; int unsigned idx; logic [31:0] data; } dexp_t;

  cexp_t       cq[$];
  dexp_t       dq[$];
  int unsigned decq[$];

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned gnt0_cnt = 0;

  // reference model state
  int unsigned m_wait = 0;
  int unsigned m_rr = 0;
  logic [31:0] exp_cpu = '0;
  bit          last_stall = 0;

  // stimulus values applied at the next cycle
  logic        c_en;
  logic [3:0]  c_we;
  logic [31:0] c_addr, c_data;
  logic        d_req[ND];
  logic [3:0]  d_we[ND];
  logic [31:0] d_addr[ND], d_data[ND];
  bit          dpend[ND];

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hCAFE_0101;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    c_en = 0; c_we = '0; c_addr = '0; c_data = '0;
    for (int k = 0; k < ND; k++) begin
      d_req[k] = 0; d_we[k] = '0; d_addr[k] = '0; d_data[k] = '0; dpend[k] = 0;
    end
  endtask

  task automatic new_dma(input int k);
    dpend[k]  = 1;
    d_we[k]   = ($urandom % 2 != 0) ? 4'h0 : 4'($urandom_range(1, 15));
    d_addr[k] = $urandom & 32'h0FFF_FFFC;
    d_data[k] = $urandom;
  endtask

  // mode 0: random mix, 1: CPU memory read stream + DMA0 always, 2: CPU idle + all DMAs
  task automatic gen(input int mode);
    int unsigned r;
    if (!last_stall) begin
      if (mode == 2) begin
        c_en = 0;
      end else if (mode == 1) begin
        c_en = 1; c_we = '0; c_addr = $urandom & 32'h0FFF_FFFC;
      end else begin
        c_en   = ($urandom % 4) != 0;
        c_we   = ($urandom % 2 != 0) ? 4'h0 : 4'($urandom_range(1, 15));
        c_data = $urandom;
        r = $urandom % 4;
        if (r < 2)       c_addr = {4'($urandom_range(3, 15)), 28'($urandom)};
        else if (r == 2) c_addr = {4'h2, 4'($urandom % NP), 24'($urandom)};
        else             c_addr = {4'h2, 4'($urandom_range(NP, 15)), 24'($urandom)};
      end
    end
    for (int k = 0; k < ND; k++) begin
      if (mode == 1 && k != 0) dpend[k] = 0;
      else if (!dpend[k] && (mode != 0 || ($urandom % 2) != 0)) new_dma(k);
      d_req[k] = dpend[k];
    end
  endtask

  // One clock: apply stimulus, compare combinational outputs with the model,
  // queue expected read returns, act as the memory, advance the model.
  task automatic run_cycle();
    logic [31:0] pd[NP];
    logic [2:0]  e_gnt, e_per;
    logic [3:0]  e_we, nib, idx;
    logic [31:0] e_addr, e_data;
    bit mmio, ph, pm, cm, anyreq, dwin, found, stall, rd_pend;
    int unsigned w;
    logic [31:0] rd_addr;
    @(negedge clk);
    bus.cpu_en_i = c_en; bus.cpu_we_i = c_we; bus.cpu_addr_i = c_addr; bus.cpu_data_i = c_data;
    for (int k = 0; k < NP; k++) begin
      pd[k] = $urandom;
      bus.per_data_i[32*k +: 32] = pd[k];
    end
    for (int k = 0; k < ND; k++) begin
      bus.dma_req_i[k] = d_req[k];
      bus.dma_we_i[4*k +: 4] = d_we[k];
      bus.dma_addr_i[32*k +: 32] = d_addr[k];
      bus.dma_data_i[32*k +: 32] = d_data[k];
    end
    #1;
    nib    = c_addr[31:28];
    idx    = c_addr[27:24];
    mmio   = c_en && nib == 4'h2;
    ph     = mmio && int'(idx) < NP;
    pm     = mmio && !ph;
    cm     = c_en && !mmio;
    anyreq = 0;
    for (int k = 0; k < ND; k++) if (d_req[k]) anyreq = 1;
    dwin  = anyreq && (!cm || m_wait == MW);
    stall = cm && dwin;
    w = 0; found = 0;
    for (int k = 0; k < ND; k++) begin
      int unsigned c;
      c = (m_rr + k) % ND;
      if (!found && d_req[c]) begin w = c; found = 1; end
    end
    e_gnt = '0; if (dwin) e_gnt[w] = 1'b1;
    e_per = '0; if (ph) e_per[idx] = 1'b1;
    e_we   = dwin ? d_we[w] : (cm ? c_we : 4'h0);
    e_addr = dwin ? d_addr[w] : c_addr;
    e_data = dwin ? d_data[w] : c_data;

    chk("cpu_stall", 32'(bus.cpu_stall_o), 32'(stall));
    chk("dma_gnt", 32'(bus.dma_gnt_o), 32'(e_gnt));
    chk("per_en", 32'(bus.per_en_o), 32'(e_per));
    chk("mem_en", 32'(bus.mem_en_o), 32'(dwin || cm));
    chk("mem_we", 32'(bus.mem_we_o), 32'(e_we));
    if (dwin || cm) begin
      chk("mem_addr", bus.mem_addr_o, e_addr);
      chk("mem_wdata", bus.mem_data_o, e_data);
    end
    if (ph) chk("per_addr_wdata", bus.per_addr_o ^ bus.per_data_o ^ 32'(bus.per_we_o),
                c_addr ^ c_data ^ 32'(c_we));

    if (c_en && c_we == 4'h0 && (mmio || !stall))
      cq.push_back('{due: cyc + 1, data: ph ? pd[idx] : (pm ? 32'h0 : rom(c_addr))});
    if (pm) decq.push_back(cyc + 1);
    if (dwin && d_we[w] == 4'h0) dq.push_back('{due: cyc + 1, idx: w, data: rom(d_addr[w])});
    if (dwin) dpend[w] = 0;
    if (bus.dma_gnt_o[0]) gnt0_cnt++;
    last_stall = stall;
    rd_pend = bus.mem_en_o && bus.mem_we_o == 4'h0;
    rd_addr = bus.mem_addr_o;
    @(posedge clk);
    m_wait = (anyreq && !dwin) ? m_wait + 1 : 0;
    if (dwin) m_rr = (w + 1) % ND;
    #1;
    bus.mem_data_i = rd_pend ? rom(rd_addr) : $urandom;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cq.delete(); dq.delete(); decq.delete();
    m_wait = 0; m_rr = 0; last_stall = 0;
    set_idle();
    bus.cpu_en_i = 0; bus.cpu_we_i = '0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
    bus.per_data_i = '0; bus.dma_req_i = '0; bus.dma_we_i = '0;
    bus.dma_addr_i = '0; bus.dma_data_i = '0; bus.mem_data_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", 32'(bus.mem_en_o), 32'h0);
    chk("rst_gnt", 32'(bus.dma_gnt_o), 32'h0);
    chk("rst_stall", 32'(bus.cpu_stall_o), 32'h0);
    rst_n = 1;
  endtask

  // Monitor: pops expected returns as they come due and compares DUT outputs
  initial begin
    logic [2:0]  e_rv;
    logic [31:0] e_dd;
    bit          e_err;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        exp_cpu = '0;
        chk("rst_cpu_data", bus.cpu_data_o, 32'h0);
        chk("rst_rvalid", 32'(bus.dma_rvalid_o), 32'h0);
        chk("rst_dec_err", 32'(bus.dec_err_o), 32'h0);
      end else begin
        if (cq.size() > 0 && cq[0].due <= cyc) begin
          exp_cpu = cq[0].data;
          void'(cq.pop_front());
        end
        chk("cpu_rdata", bus.cpu_data_o, exp_cpu);
        e_rv = '0; e_dd = '0;
        if (dq.size() > 0 && dq[0].due <= cyc) begin
          e_rv[dq[0].idx] = 1'b1;
          e_dd = dq[0].data;
          void'(dq.pop_front());
        end
        chk("dma_rvalid", 32'(bus.dma_rvalid_o), 32'(e_rv));
        if (e_rv != 3'b000) chk("dma_rdata", bus.dma_data_o, e_dd);
        e_err = 0;
        if (decq.size() > 0 && decq[0] <= cyc) begin
          e_err = 1;
          void'(decq.pop_front());
        end
        chk("dec_err", 32'(bus.dec_err_o), 32'(e_err));
      end
    end
  end

  initial begin
    do_reset();
    // lone CPU memory read: expects 0xCAFE0001 back
    set_idle(); c_en = 1; c_addr = 32'h0000_0100; run_cycle();
    set_idle(); run_cycle();
    // CPU MMIO write to slave 1 together with a DMA1 memory read
    set_idle(); c_en = 1; c_we = 4'hF; c_addr = 32'h2100_0000; c_data = 32'h1234_5678;
    d_req[1] = 1; d_addr[1] = 32'h0000_0040; run_cycle();
    // CPU read of a non-existent MMIO slave
    set_idle(); c_en = 1; c_addr = 32'h2F00_0004; run_cycle();
    set_idle(); run_cycle();
    repeat (12) begin gen(2); run_cycle(); end
    repeat (300) begin gen(0); run_cycle(); end
    // reset in the cycle after a granted DMA read
    set_idle(); run_cycle();
    set_idle(); d_req[0] = 1; d_addr[0] = 32'h0000_0200; run_cycle();
    do_reset();
    set_idle();
    gnt0_cnt = 0;
    repeat (25) begin gen(1); run_cycle(); end
    chk("dma0_gnt_every5", gnt0_cnt, 32'd5);
    repeat (200) begin gen(0); run_cycle(); end
    set_idle(); last_stall = 0;
    repeat (3) run_cycle();
    chk("drain", 32'(cq.size() + dq.size() + decq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
